// File: rtl/uart_frame_tx.sv
// UART frame transmitter: start bit, FRAME_WD data bits LSB-first, optional parity, stop bit(s).
// Internal baud divider; one-cycle tx_start strobe accepted only while idle.
module uart_frame_tx #(
  parameter int unsigned CLK_FREQUENCE = 125_000_000,
  parameter int unsigned BAUD_RATE     = 9600,
  parameter string       PARITY        = "NONE",
  parameter int unsigned FRAME_WD      = 8,
  parameter int unsigned STOP_BITS     = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tx_start,
  input  logic [FRAME_WD-1:0] tx_frame,
  output logic                tx_ready,
  output logic                tx_done,
  output logic                uart_tx
);

  localparam int unsigned BaudDiv   = CLK_FREQUENCE / BAUD_RATE;
  localparam int unsigned CntW      = (BaudDiv > 1) ? $clog2(BaudDiv) : 1;
  localparam int unsigned BitW      = $clog2(FRAME_WD + 1);
  localparam bit          HasParity = (PARITY != "NONE");
  localparam bit          OddParity = (PARITY == "ODD");

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4,
    StDone   = 3'd5
  } state_e;

  state_e              state_q;
  logic [CntW-1:0]     baud_cnt_q;
  logic [BitW-1:0]     bit_cnt_q;
  logic [FRAME_WD-1:0] shift_q;
  logic                parity_q;
  logic                bit_tick;

  assign bit_tick = (baud_cnt_q == CntW'(BaudDiv - 1));
  assign tx_ready = (state_q == StIdle);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_done    <= 1'b0;
      uart_tx    <= 1'b1;
    end else begin
      tx_done <= 1'b0;

      // Counter restarts on every bit boundary so each bit is exactly BaudDiv cycles.
      if (state_q == StIdle || state_q == StDone || bit_tick) begin
        baud_cnt_q <= '0;
      end else begin
        baud_cnt_q <= baud_cnt_q + CntW'(1);
      end

      case (state_q)
        StIdle: begin
          uart_tx <= 1'b1;
          if (tx_start) begin
            shift_q   <= tx_frame;
            parity_q  <= OddParity ? ~^tx_frame : ^tx_frame;
            bit_cnt_q <= '0;
            uart_tx   <= 1'b0;
            state_q   <= StStart;
          end
        end
        StStart: begin
          if (bit_tick) begin
            bit_cnt_q <= '0;
            uart_tx   <= shift_q[0];
            state_q   <= StData;
          end
        end
        StData: begin
          if (bit_tick) begin
            if (bit_cnt_q == BitW'(FRAME_WD - 1)) begin
              bit_cnt_q <= '0;
              if (HasParity) begin
                uart_tx <= parity_q;
                state_q <= StParity;
              end else begin
                uart_tx <= 1'b1;
                state_q <= StStop;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + BitW'(1);
              shift_q   <= shift_q >> 1;
              uart_tx   <= shift_q[1];
            end
          end
        end
        StParity: begin
          if (bit_tick) begin
            bit_cnt_q <= '0;
            uart_tx   <= 1'b1;
            state_q   <= StStop;
          end
        end
        StStop: begin
          if (bit_tick) begin
            if (bit_cnt_q == BitW'(STOP_BITS - 1)) begin
              bit_cnt_q <= '0;
              tx_done   <= 1'b1;
              state_q   <= StDone;
            end else begin
              bit_cnt_q <= bit_cnt_q + BitW'(1);
            end
          end
          uart_tx <= 1'b1;
        end
        StDone: begin
          uart_tx <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          uart_tx <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: five configurations side by side, a per-cycle frame model,
// and directed frames with hand-computed line patterns and lengths.
module tb_uart_frame_tx;

  localparam int NI = 5;
  localparam int BD = 10;
  localparam int FW  [NI] = '{8, 8, 8, 5, 9};
  localparam int PAR [NI] = '{0, 1, 2, 0, 0};  // 0 none, 1 even, 2 odd
  localparam int SB  [NI] = '{1, 1, 1, 2, 1};

  logic          clk;
  logic [NI-1:0] reset_n, tx_start, tx_ready, tx_done, uart_tx;
  logic [8:0]    frame [NI];

  int tests = 0;
  int fails = 0;

  uart_frame_tx #(.CLK_FREQUENCE(1_000_000), .BAUD_RATE(100_000), .PARITY("NONE"),
                  .FRAME_WD(8), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset_n(reset_n[0]), .tx_start(tx_start[0]), .tx_frame(frame[0][7:0]),
    .tx_ready(tx_ready[0]), .tx_done(tx_done[0]), .uart_tx(uart_tx[0]));
  uart_frame_tx #(.CLK_FREQUENCE(1_000_000), .BAUD_RATE(100_000), .PARITY("EVEN"),
                  .FRAME_WD(8), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .reset_n(reset_n[1]), .tx_start(tx_start[1]), .tx_frame(frame[1][7:0]),
    .tx_ready(tx_ready[1]), .tx_done(tx_done[1]), .uart_tx(uart_tx[1]));
  uart_frame_tx #(.CLK_FREQUENCE(1_000_000), .BAUD_RATE(100_000), .PARITY("ODD"),
                  .FRAME_WD(8), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .reset_n(reset_n[2]), .tx_start(tx_start[2]), .tx_frame(frame[2][7:0]),
    .tx_ready(tx_ready[2]), .tx_done(tx_done[2]), .uart_tx(uart_tx[2]));
  uart_frame_tx #(.CLK_FREQUENCE(1_000_000), .BAUD_RATE(100_000), .PARITY("NONE"),
                  .FRAME_WD(5), .STOP_BITS(2)) u_5n2 (
    .clk(clk), .reset_n(reset_n[3]), .tx_start(tx_start[3]), .tx_frame(frame[3][4:0]),
    .tx_ready(tx_ready[3]), .tx_done(tx_done[3]), .uart_tx(uart_tx[3]));
  uart_frame_tx #(.CLK_FREQUENCE(1_000_000), .BAUD_RATE(100_000), .PARITY("NONE"),
                  .FRAME_WD(9), .STOP_BITS(1)) u_9n1 (
    .clk(clk), .reset_n(reset_n[4]), .tx_start(tx_start[4]), .tx_frame(frame[4][8:0]),
    .tx_ready(tx_ready[4]), .tx_done(tx_done[4]), .uart_tx(uart_tx[4]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int nbits(input int i);
    return 1 + FW[i] + ((PAR[i] != 0) ? 1 : 0) + SB[i];
  endfunction

  // Line value per bit slot, slot 0 first on the wire.
  function automatic logic [12:0] build(input int i, input logic [8:0] v);
    logic [12:0] b;
    logic        p;
    int          n;
    b = '1;
    b[0] = 1'b0;
    p = 1'b0;
    n = 1;
    for (int j = 0; j < FW[i]; j++) begin
      b[n] = v[j];
      p = p ^ v[j];
      n++;
    end
    if (PAR[i] != 0) b[n] = (PAR[i] == 2) ? ~p : p;
    return b;
  endfunction

  int          cyc = 0;
  bit          armed = 0;
  bit          act  [NI];
  int          t0   [NI];
  logic [12:0] bits [NI];
  int          done_cnt [NI];

  initial begin
    for (int i = 0; i < NI; i++) begin
      act[i] = 0;
      t0[i] = 0;
      bits[i] = '1;
      done_cnt[i] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      if (reset_n == '0) armed = 1;
      for (int i = 0; i < NI; i++) begin
        if (!reset_n[i]) begin
          act[i] = 0;
        end else if (tx_start[i] && (!act[i] || cyc - t0[i] >= nbits(i) * BD + 2)) begin
          act[i] = 1;
          t0[i] = cyc;
          bits[i] = build(i, frame[i]);
        end
      end
    end
  end

  // Per-cycle compare against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        for (int i = 0; i < NI; i++) begin
          int   k;
          logic et, ed, er;
          k = cyc - t0[i];
          if (!act[i] || k > nbits(i) * BD) begin
            et = 1'b1; ed = 1'b0; er = 1'b1;
          end else if (k == nbits(i) * BD) begin
            et = 1'b1; ed = 1'b1; er = 1'b0;
          end else begin
            et = bits[i][k / BD]; ed = 1'b0; er = 1'b0;
          end
          chk($sformatf("u%0d_cyc%0d_uart_tx", i, cyc), 32'(uart_tx[i]), 32'(et));
          chk($sformatf("u%0d_cyc%0d_tx_done", i, cyc), 32'(tx_done[i]), 32'(ed));
          chk($sformatf("u%0d_cyc%0d_tx_ready", i, cyc), 32'(tx_ready[i]), 32'(er));
          if (tx_done[i] === 1'b1) done_cnt[i]++;
        end
      end
    end
  end

  // Send one word on instance i; check mid-bit line samples and accept-to-done length
  // against hand-computed literals.
  task automatic send(input int i, input logic [8:0] v, input int exp_len,
                      input logic [12:0] exp_line, input string name);
    int          len;
    logic [12:0] cap;
    @(posedge clk);
    #1 frame[i] = v;
    tx_start[i] = 1'b1;
    @(posedge clk);
    #1 tx_start[i] = 1'b0;
    frame[i] = ~v;
    cap = '0;
    len = -1;
    for (int k = 0; k < exp_len + 20 && len < 0; k++) begin
      @(negedge clk);
      if (k % BD == BD / 2 && k / BD < 13) cap[k / BD] = uart_tx[i];
      if (tx_done[i] === 1'b1) len = k;
    end
    chk({name, "_length"}, 32'(len), 32'(exp_len));
    chk({name, "_line_bits"}, 32'(cap), 32'(exp_line));
  endtask

  int d0;

  initial begin
    reset_n  = '0;
    tx_start = '0;
    for (int i = 0; i < NI; i++) frame[i] = '0;
    repeat (5) @(posedge clk);
    #1 reset_n = '1;
    @(negedge clk);
    chk("reset_uart_tx", 32'(uart_tx), 32'(5'b11111));
    chk("reset_tx_ready", 32'(tx_ready), 32'(5'b11111));
    chk("reset_tx_done", 32'(tx_done), 32'(5'b00000));
    repeat (200) @(posedge clk);

    send(0, 9'h0A5, 100, {1'b1, 8'hA5, 1'b0}, "8n1_a5");
    @(negedge clk);
    chk("8n1_a5_ready_after_done", 32'(tx_ready[0]), 32'd1);

    send(1, 9'h007, 110, {1'b1, 1'b1, 8'h07, 1'b0}, "even_07");
    send(2, 9'h007, 110, {1'b1, 1'b0, 8'h07, 1'b0}, "odd_07");

    // Busy rejection: start pulses sampled at edges 5, 50 and the DONE cycle (101).
    d0 = done_cnt[0];
    @(posedge clk);
    #1 frame[0] = 9'h03C;
    tx_start[0] = 1'b1;
    @(posedge clk);
    #1 tx_start[0] = 1'b0;
    frame[0] = 9'h0FF;
    for (int k = 1; k <= 105; k++) begin
      @(posedge clk);
      #1 tx_start[0] = (k + 1 == 5 || k + 1 == 50 || k + 1 == 101);
    end
    repeat (5) @(posedge clk);
    chk("busy_single_done", 32'(done_cnt[0] - d0), 32'd1);

    // Reset at cycle 45 of an 0x55 frame, with a simultaneous start that must be dropped.
    d0 = done_cnt[0];
    @(posedge clk);
    #1 frame[0] = 9'h055;
    tx_start[0] = 1'b1;
    @(posedge clk);
    #1 tx_start[0] = 1'b0;
    repeat (44) @(posedge clk);
    #1 reset_n[0] = 1'b0;
    tx_start[0] = 1'b1;
    @(posedge clk);
    #1 reset_n[0] = 1'b1;
    tx_start[0] = 1'b0;
    @(negedge clk);
    chk("midreset_uart_tx_high", 32'(uart_tx[0]), 32'd1);
    chk("midreset_tx_ready", 32'(tx_ready[0]), 32'd1);
    repeat (150) @(posedge clk);
    chk("midreset_no_done", 32'(done_cnt[0] - d0), 32'd0);
    send(0, 9'h055, 100, {1'b1, 8'h55, 1'b0}, "after_reset_55");

    send(3, 9'h01F, 80, {2'b11, 5'h1F, 1'b0}, "5n2_ones");
    send(3, 9'h015, 80, {2'b11, 5'h15, 1'b0}, "5n2_alt");
    send(4, 9'h1FF, 110, {1'b1, 9'h1FF, 1'b0}, "9n1_ones");
    send(4, 9'h0AA, 110, {1'b1, 9'h0AA, 1'b0}, "9n1_alt");
    repeat (20) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
